imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 133 +++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream boot loader that fills instruction memory and releases the CPU
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-high reset
//   start         one-cycle pulse; re-arms the loader from DONE or ERROR
//   in_valid      byte-stream valid
//   in_data       byte-stream payload
//   in_ready      loader can accept a byte (IDLE, LOAD, CHECK)
//   imem_we       one-cycle write strobe per assembled word
//   imem_addr     word address of the write
//   imem_wdata    assembled little-endian instruction word
//   cpu_reset     holds the CPU in reset everywhere except DONE
//   done          image loaded and checksum good
//   error         bad word count or checksum mismatch
//   words_loaded  words written since the last re-arm
//
// Stream format: count byte N, then 4*N data bytes, then one checksum byte
// equal to the XOR of all data bytes.

module imem_loader #(
    parameter int DEPTH_WORDS = 64,
    parameter int ADDR_W      = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    localparam int         NW_W      = ADDR_W + 1;
    localparam logic [8:0] DEPTH_LIM = 9'(DEPTH_WORDS);

    logic [2:0]        state;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        byte_idx;
    logic [23:0]       asm_bytes;   // bytes 0..2 of the word being assembled
    logic [7:0]        checksum;
    logic [NW_W-1:0]   n_words;
    logic              last_word;

    // Word index is ADDR_W bits wide, so the address can never reach DEPTH_WORDS.
    assign last_word = ({1'b0, word_idx} == (n_words - NW_W'(1)));

    assign in_ready  = (state == S_IDLE) || (state == S_LOAD) || (state == S_CHECK);
    assign cpu_reset = (state != S_DONE);
    assign done      = (state == S_DONE);
    assign error     = (state == S_ERROR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            word_idx     <= '0;
            byte_idx     <= 2'd0;
            asm_bytes    <= 24'd0;
            checksum     <= 8'd0;
            n_words      <= '0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= 32'd0;
            words_loaded <= '0;
        end else begin
            // Strobe is a single-cycle pulse; address and data hold their last value.
            imem_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if ((in_data == 8'd0) || ({1'b0, in_data} > DEPTH_LIM)) begin
                            state <= S_ERROR;
                        end else begin
                            state    <= S_LOAD;
                            n_words  <= NW_W'(in_data);
                            word_idx <= '0;
                            byte_idx <= 2'd0;
                        end
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        checksum <= checksum ^ in_data;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: asm_bytes[7:0]   <= in_data;
                            2'd1: asm_bytes[15:8]  <= in_data;
                            2'd2: asm_bytes[23:16] <= in_data;
                            default: begin
                                imem_we      <= 1'b1;
                                imem_addr    <= word_idx;
                                imem_wdata   <= {in_data, asm_bytes};
                                word_idx     <= word_idx + ADDR_W'(1);
                                words_loaded <= words_loaded + NW_W'(1);
                                if (last_word) begin
                                    state <= S_CHECK;
                                end
                            end
                        endcase
                    end
                end
                S_CHECK: begin
                    if (in_valid) begin
                        state <= (in_data == checksum) ? S_DONE : S_ERROR;
                    end
                end
                S_DONE, S_ERROR: begin
                    if (start) begin
                        state        <= S_IDLE;
                        checksum     <= 8'd0;
                        word_idx     <= '0;
                        byte_idx     <= 2'd0;
                        words_loaded <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
